hlt_ctl: RTL and testbench

Halt controller that produces the `stop` / `resume_n` request pair consumed by the clock-gating unit. On an HLT retirement it waits for the pipeline to drain, then requests a clock stop. On a wake event it releases the stop and holds `resume_n` low for a fixed number of cycles, forcing the gated clock to run. It sits on the free-running (ungated) clock domain, between decode/retire, the interrupt logic and the clock-gating unit.

---
 rtl/hlt_ctl_pkg.sv | 32 +++
 rtl/hlt_cnt.sv | 31 +++
 rtl/hlt_ctl.sv | 142 ++++++++++++++
 tb/tb_hlt_ctl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hlt_ctl_pkg.sv
// Shared definitions for the halt controller: state codes, wake-cause codes
// and the wake-cause priority encoder.
package hlt_ctl_pkg;

    typedef logic [1:0] hlt_state_t;

    localparam hlt_state_t ST_RUN   = 2'd0;
    localparam hlt_state_t ST_DRAIN = 2'd1;
    localparam hlt_state_t ST_STOP  = 2'd2;
    localparam hlt_state_t ST_WAKE  = 2'd3;

    typedef enum logic [1:0] {
        WC_NONE = 2'b00,
        WC_INTR = 2'b01,
        WC_NMI  = 2'b10
    } wake_cause_e;

    // NMI outranks a maskable interrupt; a masked interrupt is not a cause.
    function automatic logic [1:0] wake_code(input logic nmi_pend,
                                             input logic intr_pend,
                                             input logic intr_en);
        logic [1:0] code;
        code = WC_NONE;
        if (nmi_pend) begin
            code = WC_NMI;
        end else if (intr_pend && intr_en) begin
            code = WC_INTR;
        end
        return code;
    endfunction

endpackage

// File: rtl/hlt_cnt.sv
// Loadable down-counter with zero and one flags. Shared between the drain
// timeout and the resume pulse, which never run at the same time.
module hlt_cnt #(
    parameter int CNT_W = 5
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero,
    output logic             one
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; decrement saturates at zero.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CNT_W'(1));

endmodule

// File: rtl/hlt_ctl.sv
// Halt controller: drains the pipeline after an HLT retirement, requests a
// clock stop, and on a wake event releases the stop with a forced-run pulse.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   RUN   | core running, no halt in progress
//   DRAIN | HLT retired, waiting for pipe_empty or drain timeout
//   STOP  | clock stop requested, waiting for a wake event
//   WAKE  | stop released, resume_n held low for RESUME_CYCLES cycles
module hlt_ctl
    import hlt_ctl_pkg::*;
#(
    parameter int DRAIN_MAX     = 16,
    parameter int RESUME_CYCLES = 2,
    parameter int CNT_W         = 5
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       hlt_req,
    input  logic       pipe_empty,
    input  logic       intr_pend,
    input  logic       intr_en,
    input  logic       nmi_pend,
    output logic       stop,
    output logic       resume_n,
    output logic       halted,
    output logic       hlt_done,
    output logic [1:0] wake_cause,
    output logic       drain_to
);

    hlt_state_t       state;
    hlt_state_t       state_nxt;
    logic             wake;
    logic [1:0]       cause_now;
    logic [1:0]       cause_nxt;
    logic             done_nxt;
    logic             to_nxt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             cnt_one;

    assign wake      = nmi_pend | (intr_pend & intr_en);
    assign cause_now = wake_code(nmi_pend, intr_pend, intr_en);

    hlt_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_in   (clk_in),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero),
        .one      (cnt_one)
    );

    // Next-state, counter control and next values of the pulse/cause outputs.
    always_comb begin
        state_nxt    = state;
        cause_nxt    = wake_cause;
        done_nxt     = 1'b0;
        to_nxt       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state)
            ST_RUN: begin
                if (hlt_req) begin
                    if (wake) begin
                        // Wake already pending: the HLT completes without stopping.
                        done_nxt  = 1'b1;
                        cause_nxt = cause_now;
                    end else begin
                        state_nxt    = ST_DRAIN;
                        cause_nxt    = WC_NONE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DRAIN_MAX);
                    end
                end
            end
            ST_DRAIN: begin
                // Abort on wake beats both the drain completing and the timeout.
                if (wake) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                    cause_nxt = cause_now;
                end else if (pipe_empty) begin
                    state_nxt = ST_STOP;
                end else if (cnt_zero) begin
                    state_nxt = ST_STOP;
                    to_nxt    = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_STOP: begin
                if (wake) begin
                    state_nxt    = ST_WAKE;
                    cause_nxt    = cause_now;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(RESUME_CYCLES);
                end
            end
            ST_WAKE: begin
                // The pulse length is fixed once started; wake dropping is ignored.
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    state_nxt = ST_RUN;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // State and registered outputs, all decoded from the next state.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            stop       <= 1'b0;
            resume_n   <= 1'b1;
            halted     <= 1'b0;
            hlt_done   <= 1'b0;
            wake_cause <= WC_NONE;
            drain_to   <= 1'b0;
        end else begin
            state      <= state_nxt;
            stop       <= (state_nxt == ST_STOP);
            resume_n   <= (state_nxt != ST_WAKE);
            halted     <= (state_nxt == ST_STOP) || (state_nxt == ST_WAKE);
            hlt_done   <= done_nxt;
            wake_cause <= cause_nxt;
            drain_to   <= to_nxt;
        end
    end

endmodule

// File: tb/tb_hlt_ctl.sv
// Self-checking bench for hlt_ctl. Each halt sequence is described by the
// edge at which pipe_empty rises and the edge at which wake rises; the
// expected waveform is derived from those with plain interval arithmetic.
module tb_hlt_ctl;

    localparam int DM = 16;
    localparam int RC = 2;

    logic       clk;
    logic       rst_n;
    logic       hlt_req;
    logic       pipe_empty;
    logic       intr_pend;
    logic       intr_en;
    logic       nmi_pend;
    logic       stop;
    logic       resume_n;
    logic       halted;
    logic       hlt_done;
    logic [1:0] wake_cause;
    logic       drain_to;

    int n_checks;
    int n_fail;

    hlt_ctl #(
        .DRAIN_MAX     (DM),
        .RESUME_CYCLES (RC),
        .CNT_W         (5)
    ) dut (
        .clk_in     (clk),
        .rst_n      (rst_n),
        .hlt_req    (hlt_req),
        .pipe_empty (pipe_empty),
        .intr_pend  (intr_pend),
        .intr_en    (intr_en),
        .nmi_pend   (nmi_pend),
        .stop       (stop),
        .resume_n   (resume_n),
        .halted     (halted),
        .hlt_done   (hlt_done),
        .wake_cause (wake_cause),
        .drain_to   (drain_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        hlt_req    = 1'b0;
        pipe_empty = 1'b0;
        intr_pend  = 1'b0;
        intr_en    = 1'b0;
        nmi_pend   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({stop, resume_n, halted, hlt_done, wake_cause, drain_to} !== 7'b0100000) begin
            n_fail++;
            $display("FAIL reset_values: got stop=%b resume_n=%b halted=%b done=%b cause=%b to=%b, want 0 1 0 0 00 0",
                     stop, resume_n, halted, hlt_done, wake_cause, drain_to);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({stop, resume_n, halted, hlt_done} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_release: got stop=%b resume_n=%b halted=%b done=%b, want 0 1 0 0",
                     stop, resume_n, halted, hlt_done);
        end
    endtask

    // HLT with a wake already pending never leaves RUN.
    task automatic test_hlt_wake_in_run();
        @(negedge clk);
        hlt_req    = 1'b1;
        intr_pend  = 1'b1;
        intr_en    = 1'b1;
        pipe_empty = 1'($urandom_range(1, 0));
        @(posedge clk);
        #1;
        n_checks++;
        if ({hlt_done, wake_cause, stop, halted, resume_n} !== 6'b101001) begin
            n_fail++;
            $display("FAIL hlt_wake_run: got done=%b cause=%b stop=%b halted=%b resume_n=%b, want 1 01 0 0 1",
                     hlt_done, wake_cause, stop, halted, resume_n);
        end
        @(negedge clk);
        hlt_req = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({hlt_done, wake_cause, stop, halted} !== 5'b00100) begin
            n_fail++;
            $display("FAIL hlt_wake_run_after: got done=%b cause=%b stop=%b halted=%b, want 0 01 0 0",
                     hlt_done, wake_cause, stop, halted);
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
    endtask

    // One full halt sequence. hlt_req at edge 0; pipe_empty high from edge p;
    // wake (kind 0=nmi, 1=intr, 2=both) high from edge w >= 1. A masked
    // interrupt may be raised from edge dstart as a distractor. Extra hlt_req
    // pulses at edges n0/n1/n2 (negative = none) must be ignored.
    task automatic run_seq(input string tag, input int p, input int w, input int kind,
                           input bit distract, input int dstart,
                           input int n0, input int n1, input int n2);
        int  s_cand;
        int  s;
        int  m;
        int  e;
        bit  aborted;
        bit  timed_out;
        logic [1:0] exp_cause;
        logic exp_stop;
        logic exp_res_n;
        logic exp_halted;
        logic exp_done;
        logic exp_to;

        s_cand = (p < 1) ? 1 : p;
        timed_out = (s_cand > DM + 1);
        if (timed_out) s_cand = DM + 1;
        aborted = (w <= s_cand);
        if (aborted) begin
            s = -1;
            m = -1;
            e = w;
        end else begin
            s = s_cand;
            m = (w > s + 1) ? w : s + 1;
            e = m + RC;
        end
        exp_cause = (kind == 1) ? 2'b01 : 2'b10;

        for (int k = 0; k <= e + 2; k++) begin
            @(negedge clk);
            hlt_req    = (k == 0) || (k == n0) || (k == n1) || (k == n2);
            pipe_empty = (k >= p);
            nmi_pend   = (kind != 1) && (k >= w);
            intr_en    = (kind != 0) && (k >= w);
            intr_pend  = ((kind != 0) && (k >= w)) || (distract && (k >= dstart));
            @(posedge clk);
            #1;
            exp_stop   = !aborted && (k >= s) && (k < m);
            exp_res_n  = !(!aborted && (k >= m) && (k < m + RC));
            exp_halted = !aborted && (k >= s) && (k < e);
            exp_done   = (k == e);
            exp_to     = !aborted && timed_out && (k == s);
            n_checks++;
            if ({stop, resume_n, halted, hlt_done, drain_to} !==
                {exp_stop, exp_res_n, exp_halted, exp_done, exp_to}) begin
                n_fail++;
                $display("FAIL %s k=%0d: got stop=%b resume_n=%b halted=%b done=%b to=%b, want %b %b %b %b %b",
                         tag, k, stop, resume_n, halted, hlt_done, drain_to,
                         exp_stop, exp_res_n, exp_halted, exp_done, exp_to);
            end
            if (k >= e) begin
                n_checks++;
                if (wake_cause !== exp_cause) begin
                    n_fail++;
                    $display("FAIL %s_cause k=%0d: got %b, want %b", tag, k, wake_cause, exp_cause);
                end
            end
        end
        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_nmi_wake();
        run_seq("nmi_wake", 0, 5, 0, 1'b0, 0, -1, -1, -1);
    endtask

    task automatic test_drain_timeout();
        run_seq("drain_timeout", 1000, 30, 1, 1'b0, 0, -1, -1, -1);
        run_seq("drain_edge_pipe", DM + 1, 25, 0, 1'b0, 0, -1, -1, -1);
    endtask

    task automatic test_intr_gate();
        run_seq("intr_gate", 0, 8, 1, 1'b1, 3, -1, -1, -1);
        run_seq("intr_and_nmi", 0, 6, 2, 1'b0, 0, -1, -1, -1);
    endtask

    task automatic test_drain_abort();
        run_seq("abort_before_empty", 5, 3, 1, 1'b0, 0, -1, -1, -1);
        run_seq("abort_same_cycle", 4, 4, 0, 1'b0, 0, -1, -1, -1);
    endtask

    task automatic test_hlt_ignored();
        run_seq("hlt_ignored", 3, 10, 0, 1'b0, 0, 2, 6, 11);
    endtask

    task automatic test_reset_mid();
        // Reset while in STOP.
        @(negedge clk);
        hlt_req    = 1'b1;
        pipe_empty = 1'b1;
        @(negedge clk);
        hlt_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (stop !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_prestop: got stop=%b, want 1", stop);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({stop, resume_n, halted, wake_cause, hlt_done} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_in_stop: got stop=%b resume_n=%b halted=%b cause=%b done=%b, want 0 1 0 00 0",
                     stop, resume_n, halted, wake_cause, hlt_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({stop, halted} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_in_stop_after: got stop=%b halted=%b, want 0 0", stop, halted);
        end
        // Reset while in WAKE.
        @(negedge clk);
        hlt_req = 1'b1;
        @(negedge clk);
        hlt_req = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nmi_pend = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (resume_n !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_prewake: got resume_n=%b, want 0", resume_n);
        end
        @(negedge clk);
        rst_n    = 1'b0;
        nmi_pend = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({stop, resume_n, halted, wake_cause, hlt_done} !== 6'b010000) begin
            n_fail++;
            $display("FAIL reset_in_wake: got stop=%b resume_n=%b halted=%b cause=%b done=%b, want 0 1 0 00 0",
                     stop, resume_n, halted, wake_cause, hlt_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({resume_n, hlt_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_in_wake_after: got resume_n=%b done=%b, want 1 0", resume_n, hlt_done);
        end
    endtask

    task automatic test_random();
        int p;
        int w;
        int kind;
        int ds;
        int nz;
        bit dis;
        for (int i = 0; i < 30; i++) begin
            p    = int'($urandom_range(DM + 4, 0));
            w    = int'($urandom_range(30, 1));
            kind = int'($urandom_range(2, 0));
            dis  = 1'($urandom_range(1, 0));
            ds   = int'($urandom_range(w, 0));
            nz   = int'($urandom_range(3, 1));
            run_seq("random", p, w, kind, dis, ds, (w > nz) ? nz : -1, -1, -1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_hlt_wake_in_run();
        test_nmi_wake();
        test_drain_timeout();
        test_intr_gate();
        test_drain_abort();
        test_hlt_ignored();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
